// File: rtl/serial_add_pkg.sv
// Shared constants and helpers for the serial 2-bit-slice adder controller.
package serial_add_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int SLICE_W = 2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/full_adder_2bit.sv
// Two-bit ripple-carry adder slice used as the shared serial datapath.
module full_adder_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] s,
   output logic       cout
);

   logic [1:0] t0;
   logic [1:0] t1;

   assign t0   = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, cin};
   assign t1   = {1'b0, a[1]} + {1'b0, b[1]} + {1'b0, t0[1]};
   assign s    = {t1[0], t0[0]};
   assign cout = t1[1];

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial adder controller: adds two WIDTH-bit operands two bits per cycle.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one 2-bit slice per cycle, N = WIDTH/2 cycles
// DONE  | one-cycle done pulse; sum/cout valid
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int N  = WIDTH / SLICE_W;
   localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

   generate
      if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("serial_add_ctrl: WIDTH must be even and >= 2");
      end
   endgenerate

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [1:0]       sl_s;
   logic             sl_cout;
   logic [WIDTH-1:0] next_res;
   logic             sub_eff;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_eff = sub;
`else
   assign sub_eff = 1'b0;
`endif

   full_adder_2bit u_slice (
      .a    (a_sh[1:0]),
      .b    (b_sh[1:0]),
      .cin  (carry),
      .s    (sl_s),
      .cout (sl_cout)
   );

   // New slice bits enter at the MSB end; the oldest two bits fall off the bottom.
   assign next_res = WIDTH'({sl_s, res_sh} >> SLICE_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= sub_eff ? ~b : b;
                  carry <= sub_eff ? 1'b1 : cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> SLICE_W;
               b_sh   <= b_sh >> SLICE_W;
               carry  <= sl_cout;
               res_sh <= next_res;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  sum   <= next_res;
                  cout  <= sl_cout;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=2 instances).
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
`ifdef SERIAL_ADD_SUB_EN
   logic       sub;
   logic       sub2;
`endif

   logic       start2;
   logic [1:0] a2;
   logic [1:0] b2;
   logic       cin2;
   logic       busy2;
   logic       done2;
   logic [1:0] sum2;
   logic       cout2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] prev_sum;
   logic       prev_cout;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .cin   (cin2),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub2),
`endif
      .busy  (busy2),
      .done  (done2),
      .sum   (sum2),
      .cout  (cout2)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] s;
      logic       co;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input string nm);
      int  busy_n;
      int  done_k;
      bit  overlap;
      bit  moved;
      busy_n  = 0;
      done_k  = 0;
      overlap = 0;
      moved   = 0;
      @(negedge clk);
      a = v.a; b = v.b; cin = v.cin; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      sub = v.sub;
`endif
      @(posedge clk);
      #1;
      start = 1'b0;
      a = ~v.a; b = v.b ^ 8'h5A; cin = ~v.cin;
`ifdef SERIAL_ADD_SUB_EN
      sub = ~v.sub;
`endif
      for (int k = 1; k <= 20 && done_k == 0; k++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (busy && done) overlap = 1;
         if (!done && (sum !== prev_sum || cout !== prev_cout)) moved = 1;
         if (done) done_k = k;
      end
      chk({nm, " done_cycle"}, done_k, 5);
      chk({nm, " busy_cycles"}, busy_n, 4);
      chk({nm, " busy_done_overlap"}, {31'd0, overlap}, 0);
      chk({nm, " sum_held"}, {31'd0, moved}, 0);
      chk({nm, " sum"}, {24'd0, sum}, {24'd0, v.s});
      chk({nm, " cout"}, {31'd0, cout}, {31'd0, v.co});
      @(negedge clk);
      chk({nm, " done_one_cycle"}, {31'd0, done}, 0);
      prev_sum  = v.s;
      prev_cout = v.co;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int done_pos[$];
      int nd;
      logic [7:0] exp_s[3];
      vec_t r;

      vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0});
      vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
      vecs.push_back('{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
      vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
      vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
      vecs.push_back('{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0});
      vecs.push_back('{8'h37, 8'h37, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0; sub2 = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("reset busy", {31'd0, busy}, 0);
      chk("reset done", {31'd0, done}, 0);
      chk("reset sum", {24'd0, sum}, 0);
      chk("reset cout", {31'd0, cout}, 0);
      rst = 1'b0;
      prev_sum = 8'h00; prev_cout = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
         if (i == 1) begin
            repeat (3) @(negedge clk);
            chk("idle hold sum", {24'd0, sum}, 32'h00);
            chk("idle hold cout", {31'd0, cout}, 32'h1);
         end
      end

      // start held high, operands changed right after each acceptance
      @(negedge clk);
      a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif
      exp_s[0] = 8'h33; exp_s[1] = 8'h80; exp_s[2] = 8'h03;
      nd = 0;
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (i == 1) begin a = 8'h40; b = 8'h40; end
         if (i == 7) begin a = 8'h01; b = 8'h02; end
         if (i == 13) begin start = 1'b0; a = 8'hFF; b = 8'hFF; end
         if (done) begin
            done_pos.push_back(i);
            if (nd < 3) chk($sformatf("held sum%0d", nd), {24'd0, sum}, {24'd0, exp_s[nd]});
            nd++;
         end
      end
      chk("held done_count", nd, 3);
      chk("held done_pos0", (done_pos.size() > 0) ? done_pos[0] : -1, 5);
      chk("held done_pos1", (done_pos.size() > 1) ? done_pos[1] : -1, 11);
      chk("held done_pos2", (done_pos.size() > 2) ? done_pos[2] : -1, 17);
      prev_sum = 8'h03; prev_cout = 1'b0;

      // reset during the second RUN cycle
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", {31'd0, busy}, 0);
      chk("abort done", {31'd0, done}, 0);
      chk("abort sum", {24'd0, sum}, 0);
      chk("abort cout", {31'd0, cout}, 0);
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      chk("abort no_activity", nd, 0);
      prev_sum = 8'h00; prev_cout = 1'b0;
      r = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
      run_op(r, "after_abort");

      // WIDTH=2: single RUN cycle
      @(negedge clk);
      a2 = 2'b11; b2 = 2'b01; cin2 = 1'b1; start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;
      nd = 0;
      for (int k = 1; k <= 10 && nd == 0; k++) begin
         @(negedge clk);
         if (done2) nd = k;
      end
      chk("w2 done_cycle", nd, 2);
      chk("w2 sum", {30'd0, sum2}, 32'h1);
      chk("w2 cout", {31'd0, cout2}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
